// File: rtl/slot_scheduler_pkg.sv
// Shared types and sizing for the AXI write slot scheduler.
// Transaction classes, slot entry layout and derived widths.
package slot_scheduler_pkg;

    localparam int SLOT_AMOUNT      = 16;
    localparam int SPEC_SLOT_AMOUNT = 4;
    localparam int PID_WIDTH        = 4;
    localparam int SLOT_IDX_WIDTH   = $clog2(SLOT_AMOUNT);
    localparam int COUNT_WIDTH      = SLOT_IDX_WIDTH + 1;
    localparam int INDEX_WIDTH      = $clog2(SPEC_SLOT_AMOUNT) + 1;
    localparam int SPEC_IDX_WIDTH   = INDEX_WIDTH - 1;

    typedef logic [1:0] tran_state_t;

    localparam tran_state_t REGULAR = 2'd0;
    localparam tran_state_t BLOCK   = 2'd1;
    localparam tran_state_t DIVERT  = 2'd2;
    localparam tran_state_t UNLUCKY = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [PID_WIDTH-1:0] id;
        tran_state_t          tran_type;
    } slot;

endpackage

// File: rtl/spec_index_alloc.sv
// Speculative burst buffer index allocator: used bitmap with
// lowest-free priority pick and a release port.
module spec_index_alloc
    import slot_scheduler_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc,
    input  logic                      rel_valid,
    input  logic [SPEC_IDX_WIDTH-1:0] rel_idx,
    output logic                      any_free,
    output logic [SPEC_IDX_WIDTH-1:0] free_idx
);

    logic [SPEC_SLOT_AMOUNT-1:0] used_q;

    always_comb begin
        any_free = ~&used_q;
        free_idx = '0;
        for (int i = SPEC_SLOT_AMOUNT - 1; i >= 0; i--) begin
            if (!used_q[i]) free_idx = SPEC_IDX_WIDTH'(i);
        end
    end

    // Allocation is applied last so it wins if both touch one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
        end else begin
            if (rel_valid) used_q[rel_idx] <= 1'b0;
            if (alloc)     used_q[free_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/slot_scheduler.sv
// Outstanding AXI write tracker: circular slot table, AW classification,
// in-order retire. Optional DIVERT path gated by SLOT_SCHED_DIVERT_EN.
module slot_scheduler
    import slot_scheduler_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [PID_WIDTH-1:0]      aw_id,
    input  logic                      b_valid,
    input  logic [PID_WIDTH-1:0]      b_id,
    input  logic                      spec_release,
    input  logic [INDEX_WIDTH-2:0]    spec_release_idx,
    output logic                      alloc_valid,
    output logic [1:0]                alloc_state,
    output logic [SLOT_IDX_WIDTH-1:0] alloc_slot,
    output logic [INDEX_WIDTH-2:0]    alloc_spec_idx,
    output logic                      b_err,
    output logic [SLOT_IDX_WIDTH:0]   occupancy
);

    slot                       tbl_q [SLOT_AMOUNT];
    logic [SLOT_IDX_WIDTH-1:0] head_q;
    logic [SLOT_IDX_WIDTH-1:0] tail_q;
    logic [COUNT_WIDTH-1:0]    count_q;

    logic                      alloc_valid_q;
    tran_state_t               alloc_state_q;
    logic [SLOT_IDX_WIDTH-1:0] alloc_slot_q;
    logic                      b_err_q;

    logic                      hs;
    logic                      retire;
    logic                      aw_hit;
    tran_state_t               aw_hit_state;
    logic                      b_hit;
    logic [SLOT_IDX_WIDTH-1:0] b_hit_idx;
    tran_state_t               cls;
    logic                      spec_alloc;
    logic                      any_free;
    logic [SPEC_IDX_WIDTH-1:0] free_idx;

    assign aw_ready = count_q != COUNT_WIDTH'(SLOT_AMOUNT);
    assign hs       = aw_valid && aw_ready;
    assign retire   = (count_q != '0) && tbl_q[head_q].done;

    // Walk from head so the last aw hit is youngest, the first b hit oldest.
    always_comb begin
        logic [SLOT_IDX_WIDTH-1:0] idx;
        aw_hit       = 1'b0;
        aw_hit_state = REGULAR;
        b_hit        = 1'b0;
        b_hit_idx    = '0;
        idx          = '0;
        for (int k = 0; k < SLOT_AMOUNT; k++) begin
            idx = head_q + SLOT_IDX_WIDTH'(k);
            if (tbl_q[idx].valid && !tbl_q[idx].done) begin
                if (tbl_q[idx].id == aw_id) begin
                    aw_hit       = 1'b1;
                    aw_hit_state = tbl_q[idx].tran_type;
                end
                if (tbl_q[idx].id == b_id && !b_hit) begin
                    b_hit     = 1'b1;
                    b_hit_idx = idx;
                end
            end
        end
    end

`ifdef SLOT_SCHED_DIVERT_EN
    logic [SPEC_IDX_WIDTH-1:0] alloc_spec_q;

    always_comb begin
        cls        = REGULAR;
        spec_alloc = 1'b0;
        if (aw_hit) begin
            if (aw_hit_state == DIVERT || aw_hit_state == UNLUCKY) begin
                cls = UNLUCKY;
            end else if (any_free) begin
                cls        = DIVERT;
                spec_alloc = hs;
            end else begin
                cls = BLOCK;
            end
        end
    end

    spec_index_alloc u_spec (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (spec_alloc),
        .rel_valid (spec_release),
        .rel_idx   (spec_release_idx),
        .any_free  (any_free),
        .free_idx  (free_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_spec_q <= '0;
        end else if (hs) begin
            alloc_spec_q <= (cls == DIVERT) ? free_idx : '0;
        end
    end

    assign alloc_spec_idx = alloc_spec_q;
`else
    logic unused_spec;

    assign cls            = aw_hit ? BLOCK : REGULAR;
    assign spec_alloc     = 1'b0;
    assign any_free       = 1'b0;
    assign free_idx       = '0;
    assign alloc_spec_idx = '0;
    assign unused_spec    = ^{spec_release, spec_release_idx,
                              aw_hit_state, spec_alloc,
                              any_free, free_idx};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_AMOUNT; i++) tbl_q[i] <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            alloc_valid_q <= 1'b0;
            alloc_state_q <= REGULAR;
            alloc_slot_q  <= '0;
            b_err_q       <= 1'b0;
        end else begin
            alloc_valid_q <= hs;
            b_err_q       <= b_valid && !b_hit;
            if (hs) begin
                alloc_state_q <= cls;
                alloc_slot_q  <= tail_q;
                tbl_q[tail_q] <= '{valid: 1'b1, done: 1'b0,
                                   id: aw_id, tran_type: cls};
                tail_q        <= tail_q + 1'b1;
            end
            if (b_valid && b_hit) tbl_q[b_hit_idx].done <= 1'b1;
            if (retire) begin
                tbl_q[head_q].valid <= 1'b0;
                tbl_q[head_q].done  <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            count_q <= count_q + COUNT_WIDTH'(hs) - COUNT_WIDTH'(retire);
        end
    end

    assign alloc_valid = alloc_valid_q;
    assign alloc_state = alloc_state_q;
    assign alloc_slot  = alloc_slot_q;
    assign b_err       = b_err_q;
    assign occupancy   = count_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed vector bench for slot_scheduler, valid with or without
// SLOT_SCHED_DIVERT_EN defined.
module tb_slot_scheduler;
    import slot_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       aw_valid = 1'b0;
    logic       aw_ready;
    logic [3:0] aw_id = '0;
    logic       b_valid = 1'b0;
    logic [3:0] b_id = '0;
    logic       spec_release = 1'b0;
    logic [1:0] spec_release_idx = '0;
    logic       alloc_valid;
    logic [1:0] alloc_state;
    logic [3:0] alloc_slot;
    logic [1:0] alloc_spec_idx;
    logic       b_err;
    logic [4:0] occupancy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit       aw;
        bit [3:0] aid;
        bit       b;
        bit [3:0] bid;
        bit       rel;
        bit [1:0] ridx;
        bit       av;
        bit [1:0] st_d;
        bit [1:0] st_n;
        bit [3:0] slt;
        bit [1:0] sp;
        bit       be;
        int       occ;
    } vec_t;

    vec_t vq[$];

    slot_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .aw_valid         (aw_valid),
        .aw_ready         (aw_ready),
        .aw_id            (aw_id),
        .b_valid          (b_valid),
        .b_id             (b_id),
        .spec_release     (spec_release),
        .spec_release_idx (spec_release_idx),
        .alloc_valid      (alloc_valid),
        .alloc_state      (alloc_state),
        .alloc_slot       (alloc_slot),
        .alloc_spec_idx   (alloc_spec_idx),
        .b_err            (b_err),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit aw, int aid, bit b, int bid,
                                bit rel, int ridx, bit av, int st_d,
                                int st_n, int slt, int sp, bit be,
                                int occ);
        vec_t v;
        v.aw = aw; v.aid = 4'(aid); v.b = b; v.bid = 4'(bid);
        v.rel = rel; v.ridx = 2'(ridx); v.av = av;
        v.st_d = 2'(st_d); v.st_n = 2'(st_n); v.slt = 4'(slt);
        v.sp = 2'(sp); v.be = be; v.occ = occ;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step(vec_t v, int n);
        bit [1:0] st;
`ifdef SLOT_SCHED_DIVERT_EN
        st = v.st_d;
`else
        st = v.st_n;
`endif
        @(negedge clk);
        aw_valid = v.aw; aw_id = v.aid;
        b_valid = v.b; b_id = v.bid;
        spec_release = v.rel; spec_release_idx = v.ridx;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d alloc_valid", n), int'(alloc_valid), int'(v.av));
        chk($sformatf("v%0d b_err", n), int'(b_err), int'(v.be));
        chk($sformatf("v%0d occupancy", n), int'(occupancy), v.occ);
        chk($sformatf("v%0d aw_ready", n), int'(aw_ready), int'(v.occ != 16));
        if (v.av) begin
            chk($sformatf("v%0d state", n), int'(alloc_state), int'(st));
            chk($sformatf("v%0d slot", n), int'(alloc_slot), int'(v.slt));
`ifdef SLOT_SCHED_DIVERT_EN
            if (st == DIVERT)
                chk($sformatf("v%0d spec", n), int'(alloc_spec_idx), int'(v.sp));
`else
            chk($sformatf("v%0d spec", n), int'(alloc_spec_idx), 0);
`endif
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " aw_ready"}, int'(aw_ready), 1);
        chk({tag, " alloc_valid"}, int'(alloc_valid), 0);
        chk({tag, " alloc_state"}, int'(alloc_state), int'(REGULAR));
        chk({tag, " alloc_slot"}, int'(alloc_slot), 0);
        chk({tag, " alloc_spec_idx"}, int'(alloc_spec_idx), 0);
        chk({tag, " b_err"}, int'(b_err), 0);
        chk({tag, " occupancy"}, int'(occupancy), 0);
    endtask

    localparam int R = 0, K = 1, D = 2, U = 3;

    initial begin
        //          aw aid b bid rel ri av st_d st_n slt sp be occ
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, R, R, 0, 0, 0, 1));
        vq.push_back(mk(1, 5, 0, 0, 0, 0, 1, R, R, 1, 0, 0, 2));
        vq.push_back(mk(1, 5, 0, 0, 0, 0, 1, D, K, 2, 0, 0, 3));
        vq.push_back(mk(1, 5, 0, 0, 0, 0, 1, U, K, 3, 0, 0, 4));
        vq.push_back(mk(0, 0, 1, 9, 0, 0, 0, R, R, 0, 0, 1, 4));
        vq.push_back(mk(1, 9, 1, 9, 0, 0, 1, R, R, 4, 0, 1, 5));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, D, K, 5, 1, 0, 6));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, R, R, 6, 0, 0, 7));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, D, K, 7, 2, 0, 8));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 1, R, R, 8, 0, 0, 9));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 1, D, K, 9, 3, 0, 10));
        vq.push_back(mk(1, 6, 0, 0, 0, 0, 1, R, R, 10, 0, 0, 11));
        vq.push_back(mk(1, 6, 0, 0, 0, 0, 1, K, K, 11, 0, 0, 12));
        vq.push_back(mk(1, 6, 0, 0, 1, 2, 1, K, K, 12, 0, 0, 13));
        vq.push_back(mk(1, 6, 0, 0, 0, 0, 1, D, K, 13, 2, 0, 14));
        vq.push_back(mk(0, 0, 1, 5, 0, 0, 0, R, R, 0, 0, 0, 14));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 14));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 0, R, R, 0, 0, 0, 14));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 13));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 12));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 12));
        vq.push_back(mk(1, 7, 0, 0, 0, 0, 1, R, R, 14, 0, 0, 13));
        vq.push_back(mk(1, 8, 0, 0, 0, 0, 1, R, R, 15, 0, 0, 14));
        vq.push_back(mk(1, 10, 0, 0, 0, 0, 1, R, R, 0, 0, 0, 15));
        vq.push_back(mk(1, 11, 0, 0, 0, 0, 1, R, R, 1, 0, 0, 16));
        vq.push_back(mk(1, 12, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 16));
        vq.push_back(mk(1, 12, 1, 5, 0, 0, 0, R, R, 0, 0, 0, 16));
        vq.push_back(mk(1, 12, 0, 0, 0, 0, 0, R, R, 0, 0, 0, 15));
        vq.push_back(mk(1, 12, 0, 0, 0, 0, 1, R, R, 2, 0, 0, 16));

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) step(vq[i], i);

        // Asynchronous reset mid-cycle with a full table and spec slots held.
        @(negedge clk);
        aw_valid = 1'b0; b_valid = 1'b0; spec_release = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 5, 0, 0, 0, 0, 1, R, R, 0, 0, 0, 1), 100);
        step(mk(1, 5, 0, 0, 0, 0, 1, D, K, 1, 0, 0, 2), 101);

        @(negedge clk);
        aw_valid = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
